// File: rtl/sr_ff_monitor.sv
// Reference monitor for an SR flip-flop: tracks the expected q, compares the
// flop's q/q_bar every clock and keeps saturating pass/fail statistics.
module sr_ff_monitor #(
   parameter int unsigned CNT_W = 8,
   parameter int unsigned CYC_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             s,
   input  logic             r,
   input  logic             q,
   input  logic             q_bar,
   output logic             exp_valid,
   output logic             exp_q,
   output logic             err,
   output logic             err_sticky,
   output logic [CNT_W-1:0] chk_cnt,
   output logic [CNT_W-1:0] err_cnt,
   output logic [CNT_W-1:0] forbid_cnt,
   output logic [CYC_W-1:0] first_err_cyc,
   output logic [CYC_W-1:0] cyc
);

   localparam logic [CNT_W-1:0] CNT_MAX = '1;

   typedef enum logic {
      UNK   = 1'b0,
      VALID = 1'b1
   } state_t;

   state_t state;
   state_t state_nxt;
   logic   exp_q_nxt;
   logic   mismatch;
   logic   forbid;

   // Model update from s/r; comparison always uses the pre-edge expectation.
   always_comb begin
      state_nxt = state;
      exp_q_nxt = exp_q;
      mismatch  = 1'b0;
      forbid    = s & r;
      if (state == VALID) begin
         mismatch = (q !== exp_q) || (q_bar !== ~exp_q);
      end
      unique case ({s, r})
         2'b10: begin
            state_nxt = VALID;
            exp_q_nxt = 1'b1;
         end
         2'b01: begin
            state_nxt = VALID;
            exp_q_nxt = 1'b0;
         end
         2'b11: state_nxt = UNK;
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state         <= UNK;
         exp_q         <= 1'b0;
         err           <= 1'b0;
         err_sticky    <= 1'b0;
         chk_cnt       <= '0;
         err_cnt       <= '0;
         forbid_cnt    <= '0;
         first_err_cyc <= '0;
         cyc           <= '0;
      end else begin
         state      <= state_nxt;
         exp_q      <= exp_q_nxt;
         err        <= mismatch;
         cyc        <= cyc + CYC_W'(1);
         if (state == VALID && chk_cnt != CNT_MAX) begin
            chk_cnt <= chk_cnt + CNT_W'(1);
         end
         if (mismatch) begin
            err_sticky <= 1'b1;
            if (err_cnt != CNT_MAX) begin
               err_cnt <= err_cnt + CNT_W'(1);
            end
            if (!err_sticky) begin
               first_err_cyc <= cyc;
            end
         end
         if (forbid && forbid_cnt != CNT_MAX) begin
            forbid_cnt <= forbid_cnt + CNT_W'(1);
         end
      end
   end

   assign exp_valid = (state == VALID);

endmodule

// File: tb/tb_sr_ff_monitor.sv
// Scoreboard bench for sr_ff_monitor: an emulated SR flop drives q/q_bar,
// a behavioural model predicts every output after each clock edge.
module tb_sr_ff_monitor;

   localparam int unsigned CNT_W   = 4;
   localparam int unsigned CYC_W   = 16;
   localparam int          CNT_TOP = (1 << CNT_W) - 1;
   localparam int          CYC_MOD = 1 << CYC_W;

   logic             clk = 1'b0;
   logic             rst = 1'b1;
   logic             s = 1'b0;
   logic             r = 1'b0;
   logic             q = 1'b0;
   logic             q_bar = 1'b1;
   logic             exp_valid;
   logic             exp_q;
   logic             err;
   logic             err_sticky;
   logic [CNT_W-1:0] chk_cnt;
   logic [CNT_W-1:0] err_cnt;
   logic [CNT_W-1:0] forbid_cnt;
   logic [CYC_W-1:0] first_err_cyc;
   logic [CYC_W-1:0] cyc;

   sr_ff_monitor #(.CNT_W(CNT_W), .CYC_W(CYC_W)) dut (
      .clk(clk), .rst(rst), .s(s), .r(r), .q(q), .q_bar(q_bar),
      .exp_valid(exp_valid), .exp_q(exp_q), .err(err), .err_sticky(err_sticky),
      .chk_cnt(chk_cnt), .err_cnt(err_cnt), .forbid_cnt(forbid_cnt),
      .first_err_cyc(first_err_cyc), .cyc(cyc)
   );

   always #5 clk = ~clk;

   typedef struct {
      bit ev;
      bit eq;
      bit er;
      bit sticky;
      int chk;
      int errc;
      int forb;
      int first;
      int cy;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   // Model: expected q as -1 (unknown), 0 or 1, plus plain integer statistics.
   int m_exp = -1;
   int m_chk = 0, m_errc = 0, m_forb = 0, m_first = 0, m_cyc = 0;
   bit m_err = 0, m_sticky = 0;
   bit ff_q = 0;

   task automatic cmp(input string name, input int act, input int req);
      total++;
      if (act != req) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
      end
   endtask

   function automatic int sat(input int v);
      return (v >= CNT_TOP) ? CNT_TOP : v + 1;
   endfunction

   task automatic model_edge(input bit rst_i, input bit s_i, input bit r_i,
                             input bit q_i, input bit qb_i);
      exp_t e;
      if (rst_i) begin
         m_exp = -1; m_chk = 0; m_errc = 0; m_forb = 0; m_first = 0;
         m_cyc = 0; m_err = 0; m_sticky = 0;
      end else begin
         m_err = 0;
         if (m_exp >= 0) begin
            m_chk = sat(m_chk);
            if (int'(q_i) != m_exp || int'(qb_i) != 1 - m_exp) begin
               m_err = 1;
               m_errc = sat(m_errc);
               if (!m_sticky) m_first = m_cyc;
               m_sticky = 1;
            end
         end
         if (s_i && r_i) m_forb = sat(m_forb);
         m_cyc = (m_cyc + 1) % CYC_MOD;
         if (s_i && !r_i) m_exp = 1;
         else if (!s_i && r_i) m_exp = 0;
         else if (s_i && r_i) m_exp = -1;
      end
      e.ev = (m_exp >= 0); e.eq = (m_exp == 1); e.er = m_err; e.sticky = m_sticky;
      e.chk = m_chk; e.errc = m_errc; e.forb = m_forb; e.first = m_first; e.cy = m_cyc;
      sb.push_back(e);
   endtask

   // Drive one cycle. Output modes: 0 correct flop, 1 force 0, 2 force 1, 3 random.
   task automatic step(input bit rst_i, input bit s_i, input bit r_i,
                       input int qm, input int qbm);
      bit qv, qbv;
      @(negedge clk);
      qv  = (qm == 0) ? ff_q  : (qm == 1) ? 1'b0 : (qm == 2) ? 1'b1 : 1'($urandom % 2);
      qbv = (qbm == 0) ? ~ff_q : (qbm == 1) ? 1'b0 : (qbm == 2) ? 1'b1 : 1'($urandom % 2);
      rst = rst_i; s = s_i; r = r_i; q = qv; q_bar = qbv;
      model_edge(rst_i, s_i, r_i, qv, qbv);
      if (s_i && !r_i) ff_q = 1'b1;
      else if (!s_i && r_i) ff_q = 1'b0;
      else if (s_i && r_i) ff_q = 1'($urandom % 2);
   endtask

   task automatic sample();
      @(posedge clk);
      #1;
   endtask

   // Monitor: one expected record per edge, checked 1 ns after that edge.
   always begin
      exp_t e;
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
         e = sb.pop_front();
         cmp("exp_valid", int'(exp_valid), int'(e.ev));
         if (e.ev) cmp("exp_q", int'(exp_q), int'(e.eq));
         cmp("err", int'(err), int'(e.er));
         cmp("err_sticky", int'(err_sticky), int'(e.sticky));
         cmp("chk_cnt", int'(chk_cnt), e.chk);
         cmp("err_cnt", int'(err_cnt), e.errc);
         cmp("forbid_cnt", int'(forbid_cnt), e.forb);
         cmp("first_err_cyc", int'(first_err_cyc), e.first);
         cmp("cyc", int'(cyc), e.cy);
      end
   end

   initial begin
      bit [1:0] v;
      ff_q = 1'($urandom % 2);

      // Reset then idle: model must stay unknown.
      step(1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(0, 0, 0, 0, 0);
      sample();
      cmp("idle_exp_valid", int'(exp_valid), 0);
      cmp("idle_chk_cnt", int'(chk_cnt), 0);

      // Counting pattern with a correct flop.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 32; i++) begin
         v = 2'((i / 2) % 4);
         step(0, v[1], v[0], 0, 0);
      end
      sample();
      cmp("count_forbid_cnt", int'(forbid_cnt), 8);
      cmp("count_err_cnt", int'(err_cnt), 0);
      cmp("count_err_sticky", int'(err_sticky), 0);
      cmp("count_exp_valid_after_11", int'(exp_valid), 0);

      // Single fault: q forced low one cycle after a set edge.
      step(1, 0, 0, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 1, 0);
      sample();
      cmp("fault_err", int'(err), 1);
      cmp("fault_first_err_cyc", int'(first_err_cyc), 4);
      step(0, 0, 0, 0, 0);
      sample();
      cmp("fault_err_one_cycle", int'(err), 0);
      cmp("fault_err_cnt", int'(err_cnt), 1);
      cmp("fault_err_sticky", int'(err_sticky), 1);

      // q_bar stuck high with exp_q=1: error count saturates.
      step(0, 1, 0, 0, 0);
      for (int i = 0; i < 18; i++) step(0, 1, 0, 0, 2);
      sample();
      cmp("sat_err_cnt", int'(err_cnt), CNT_TOP);
      cmp("sat_err", int'(err), 1);

      // Mid-run reset clears all history.
      step(1, 1, 0, 0, 2);
      sample();
      cmp("rst_err_cnt", int'(err_cnt), 0);
      cmp("rst_err_sticky", int'(err_sticky), 0);
      cmp("rst_cyc", int'(cyc), 0);
      cmp("rst_exp_valid", int'(exp_valid), 0);
      for (int i = 0; i < 10; i++) step(0, 1'($urandom % 2), 1'($urandom % 2), 0, 0);
      sample();
      cmp("clean_err_sticky", int'(err_sticky), 0);

      // Forbidden input drops the model; arbitrary q is ignored until re-armed.
      step(0, 1, 0, 0, 0);
      step(0, 0, 0, 0, 0);
      step(0, 1, 1, 0, 0);
      for (int i = 0; i < 3; i++) step(0, 0, 0, 3, 3);
      sample();
      cmp("unk_exp_valid", int'(exp_valid), 0);
      cmp("unk_err_sticky", int'(err_sticky), 0);
      step(0, 0, 1, 3, 3);
      sample();
      cmp("rearm_exp_valid", int'(exp_valid), 1);
      cmp("rearm_exp_q", int'(exp_q), 0);
      step(0, 0, 0, 0, 0);

      // Random traffic with occasional faults and resets.
      for (int i = 0; i < 400; i++) begin
         step(($urandom % 50) == 0, 1'($urandom % 2), 1'($urandom % 2),
              (($urandom % 20) == 0) ? 3 : 0, (($urandom % 20) == 0) ? 3 : 0);
      end
      sample();
      sample();
      cmp("scoreboard_drained", sb.size(), 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sr_ff_monitor.md
# sr_ff_monitor

Self-checking response monitor for an SR flip-flop under test. It samples the same `s`/`r` stimulus the flip-flop receives and keeps a cycle-accurate reference model of `q`. It compares the flip-flop's `q`/`q_bar` against that model every clock and accumulates pass/fail statistics. It sits beside the flip-flop in simulation benches and on-board self-test harnesses, acting as the receiving end of the stimulus-generator/DUT pair.

## Interface
- `CNT_W`, default 8: width of the saturating check, error and forbidden-input counters.
- `CYC_W`, default 16: width of the free-running cycle counter and the first-error timestamp.
- `clk  in  1`: clock; the same clock that drives the monitored flip-flop.
- `rst  in  1`: reset; one clock, reset is synchronous and active-high.
- `s  in  1`: set input as seen by the flip-flop.
- `r  in  1`: reset input as seen by the flip-flop.
- `q  in  1`: flip-flop output under check.
- `q_bar  in  1`: flip-flop complementary output under check.
- `exp_valid  out  1`: the model holds a known expected value.
- `exp_q  out  1`: expected `q` for the current cycle.
- `err  out  1`: one-cycle pulse, a mismatch was detected at the previous edge.
- `err_sticky  out  1`: set on the first mismatch; cleared only by `rst`.
- `chk_cnt  out  CNT_W`: number of comparisons performed, saturating.
- `err_cnt  out  CNT_W`: number of mismatches, saturating.
- `forbid_cnt  out  CNT_W`: number of edges sampled with `s=r=1`, saturating.
- `first_err_cyc  out  CYC_W`: value of `cyc` when the first mismatch was detected.
- `cyc  out  CYC_W`: free-running cycle counter; wraps at 2^CYC_W.

## Operation
- Model state machine, with states `UNK` and `VALID`. The `exp_q` register is valid only in `VALID`.
  - `UNK` with `{s,r}=10` -> `VALID`, `exp_q=1`.
  - `UNK` with `{s,r}=01` -> `VALID`, `exp_q=0`.
  - `UNK` with `00` or `11` -> stay in `UNK`.
  - `VALID` with `00` -> hold `exp_q`.
  - `VALID` with `10` -> `exp_q=1`.
  - `VALID` with `01` -> `exp_q=0`.
  - `VALID` with `11` -> `UNK` (forbidden input; the output is undefined).
- Forbidden input: every edge with `s=r=1` increments `forbid_cnt`, in any state. It is not an error.
- Comparison: at each edge where the state before the edge is `VALID`, the monitor checks `q == exp_q` and `q_bar == ~exp_q`.
  - Each comparison increments `chk_cnt`.
  - Either check failing counts as one mismatch: `err` is high for the following cycle, `err_cnt` increments, and `err_sticky` is set.
  - If `err_sticky` was 0, `cyc` is captured into `first_err_cyc`.
- No comparison is made while in `UNK`, including the edge that leaves `UNK`.
- Counter saturation: `chk_cnt`, `err_cnt` and `forbid_cnt` stop at 2^CNT_W-1.
- X/Z on `q` or `q_bar` during a comparison counts as a mismatch (case-inequality compare).
- Reset values:
  - state `UNK`, so `exp_valid=0`
  - `exp_q=0`, `err=0`, `err_sticky=0`
  - all counters 0, `first_err_cyc=0`, `cyc=0`
- `rst` asserted mid-run discards all history at that edge. Stimulus sampled on the reset edge is ignored, and the model restarts in `UNK`.

## Timing
- All sampling and all output updates occur on the rising edge of `clk`. There are no combinational paths from inputs to outputs.
- Edge k samples `s`/`r`, and the flip-flop updates `q` at that same edge.
- Edge k+1 compares the settled `q`/`q_bar` against the `exp_q` produced at edge k. `err` and the counters reflect that comparison from edge k+1 onward.
- Latency from stimulus edge to the error report is therefore 1 cycle. `err` is high for exactly one cycle per mismatch, and consecutive mismatches keep it high.
- Simultaneous events within one edge:
  - A comparison uses the old `exp_q`, and the model update uses the new `s`/`r`, in the same edge.
  - A forbidden input in `VALID` still compares at that edge, then moves to `UNK`.
- `cyc` increments every non-reset edge. The first edge after reset release reads `cyc=0` and captures 0 if that edge detects an error.

## Test plan
- Reset, then hold `s=r=0` for 10 cycles -> `exp_valid=0`, `chk_cnt=0`, `err` never set.
- Correct DUT driven with `{s,r}` counting 00,01,10,11 and repeating, two cycles per value, for 32 cycles:
  - `err_sticky=0`, `err_cnt=0`.
  - `forbid_cnt=8` (4 visits to 11, each held for 2 edges).
  - `exp_valid` drops after each 11.
- Correct DUT, apply `10` then a faulty `q` forced to 0 one cycle after the set edge:
  - `err=1` for exactly 1 cycle.
  - `err_cnt=1`, `err_sticky=1`.
  - `first_err_cyc` equals `cyc` at the detecting edge.
- `q` correct but `q_bar` stuck at 1 while in `VALID` with `exp_q=1` -> a mismatch counted each cycle. With `CNT_W=4`, `err_cnt` saturates at 15 after 15+ cycles.
- Mid-run `rst` after errors -> all outputs return to their reset values the next cycle. A following clean run shows `err_sticky=0`.
- `VALID` with `exp_q=1`, then `11` for one cycle, then `00` with `q` arbitrary:
  - No error on the `00` cycles.
  - The next `01` re-arms the model, with `exp_q=0` and checking resuming one edge later.
